// File: rtl/game_pkg.sv
// Shared types and constants for the colour-sequence game: colour encoding,
// sequence packing widths, player FSM states and the colour-to-LED helper.
package game_pkg;

  localparam int SEQ_MAX  = 16;
  localparam int COLOUR_W = 2;
  localparam int SEQ_W    = 32;
  localparam int LEN_W    = 4;
  localparam int LED_W    = 1 << COLOUR_W;

  typedef enum logic [COLOUR_W-1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    BLUE   = 2'd2,
    YELLOW = 2'd3
  } colour_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ON,
    ST_OFF,
    ST_FIN
  } player_state_t;

  function automatic logic [LED_W-1:0] colour_to_onehot(input colour_t c);
    logic [LED_W-1:0] oh;
    oh    = '0;
    oh[c] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter with tick enable and zero flag; times both the lit
// and the dark phase of each colour.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sequence_player.sv
// Plays a latched 2-bit-per-colour sequence onto four one-hot LEDs with a lit
// phase and a dark gap per colour. Optional tone output: SEQ_PLAYER_TONE_EN.
module sequence_player
  import game_pkg::*;
#(
  parameter int ON_CYCLES  = 8,
  parameter int OFF_CYCLES = 4,
  parameter int CNT_W      = 8
`ifdef SEQ_PLAYER_TONE_EN
  ,
  parameter int TONE_DIV_BASE = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic             abort,
  input  logic [SEQ_W-1:0] sequence_word,
  input  logic [LEN_W-1:0] sequence_len,
  output logic [LED_W-1:0] led,
  output logic [1:0]       colour_out,
  output logic             busy,
  output logic             done
`ifdef SEQ_PLAYER_TONE_EN
  ,
  output logic             tone
`endif
);

  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);

  player_state_t    state_q, state_d;
  logic [SEQ_W-1:0] seq_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] index_q;
  logic             latch_en;
  logic             index_inc;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic             tmr_en;
  logic             tmr_zero;
  logic [CNT_W-1:0] tmr_count;
  colour_t          cur_colour;

  phase_timer #(.CNT_W(CNT_W)) u_phase_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (tmr_en),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .count    (tmr_count),
    .zero     (tmr_zero)
  );

  // NOTE: every signal gets a default first so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    latch_en     = 1'b0;
    index_inc    = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = ON_LOAD;
    tmr_en       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          latch_en = 1'b1;
          tmr_load = 1'b1;
          state_d  = ST_ON;
        end
      end
      ST_ON: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (en) begin
          if (tmr_zero) begin
            tmr_load     = 1'b1;
            tmr_load_val = OFF_LOAD;
            state_d      = ST_OFF;
          end else begin
            tmr_en = 1'b1;
          end
        end
      end
      ST_OFF: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (en) begin
          if (!tmr_zero) begin
            tmr_en = 1'b1;
          end else if (index_q == len_q) begin
            state_d = ST_FIN;
          end else begin
            index_inc = 1'b1;
            tmr_load  = 1'b1;
            state_d   = ST_ON;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the latched sequence is a plain register, so it resets with the rest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      seq_q   <= '0;
      len_q   <= '0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        seq_q   <= sequence_word;
        len_q   <= sequence_len;
        index_q <= '0;
      end else if (index_inc) begin
        index_q <= index_q + LEN_W'(1);
      end
    end
  end

  assign cur_colour = colour_t'(seq_q[{index_q, 1'b0} +: COLOUR_W]);
  assign led        = (state_q == ST_ON) ? colour_to_onehot(cur_colour) : '0;
  assign colour_out = (state_q == ST_ON) ? cur_colour : RED;
  assign busy       = (state_q == ST_ON) || (state_q == ST_OFF);
  assign done       = (state_q == ST_FIN);

`ifdef SEQ_PLAYER_TONE_EN
  localparam int TONE_W = $clog2(TONE_DIV_BASE * LED_W + 1);

  logic [TONE_W-1:0] tone_cnt_q;
  logic [TONE_W-1:0] tone_half;

  assign tone_half = TONE_W'(TONE_DIV_BASE * (int'(cur_colour) + 1));

  // Leaving ON clears the divider, so each lit phase starts with tone low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_cnt_q <= '0;
      tone       <= 1'b0;
    end else if (state_q != ST_ON) begin
      tone_cnt_q <= '0;
      tone       <= 1'b0;
    end else if (tone_cnt_q == tone_half - TONE_W'(1)) begin
      tone_cnt_q <= '0;
      tone       <= ~tone;
    end else begin
      tone_cnt_q <= tone_cnt_q + TONE_W'(1);
    end
  end
`endif

endmodule
